// File: rtl/rb_pkg.sv
// Shared types and constants for the RB signal-generator blocks.
// Holds the OSC1 sweep state encoding and the DDS increment width.
package rb_pkg;

   localparam int RB_OSC1_INC_W = 48;
   localparam int RB_SWP_STEP_W = 32;
   localparam int RB_SWP_DWELL_W = 16;
   localparam int RB_SWP_CNT_W = 16;

   typedef enum logic [1:0] {
      RB_SWP_IDLE,
      RB_SWP_EMIT,
      RB_SWP_DWELL,
      RB_SWP_FIN
   } rb_swp_state_t;

endpackage

// File: rtl/rb_clamp_addsub.sv
// Add or subtract with one extra carry bit, clamped to a window.
// Upward results saturate at hi, downward results at lo (incl. borrow).
module rb_clamp_addsub
   import rb_pkg::*;
#(
   parameter int W = RB_OSC1_INC_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] hi,
   input  logic         sub,
   output logic [W-1:0] y
);

   logic [W:0] s;

   always_comb begin
      s = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      y = s[W-1:0];
      if (sub) begin
         if (s[W] || (s[W-1:0] <= lo)) y = lo;
      end else if (s >= {1'b0, hi}) begin
         y = hi;
      end
   end

endmodule

// File: rtl/rb_osc1_sweep.sv
// OSC1 phase-increment sweep source: linear start->stop ramp with
// per-step dwell, single-shot / repeat / up-down modes, AXI-S output.
module rb_osc1_sweep
   import rb_pkg::*;
#(
   parameter int INC_W   = RB_OSC1_INC_W,
   parameter int STEP_W  = RB_SWP_STEP_W,
   parameter int DWELL_W = RB_SWP_DWELL_W
) (
   input  logic               clk_adc_125mhz,
   input  logic               adc_rstn_i,
   input  logic [INC_W-1:0]   cfg_start_inc,
   input  logic [INC_W-1:0]   cfg_stop_inc,
   input  logic [STEP_W-1:0]  cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_repeat,
   input  logic               cfg_bidir,
   input  logic               start,
   input  logic               abort,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic [INC_W-1:0]   m_axis_tdata,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic [15:0]        step_cnt
);

   rb_swp_state_t state, state_n;

   logic [INC_W-1:0]   start_q, stop_q, pend, nxt, sum;
   logic [STEP_W-1:0]  step_q;
   logic [DWELL_W-1:0] dwell_q, cnt;
   logic rep_q, bidir_q, dir_dn, dir_n;
   logic hs, term, reload, bad, arm;

   assign m_axis_tvalid = (state == RB_SWP_EMIT);
   assign busy = (state != RB_SWP_IDLE);
   assign hs = m_axis_tvalid & m_axis_tready;
   assign arm = (state == RB_SWP_IDLE) & start & ~abort;
   assign bad = (cfg_start_inc > cfg_stop_inc)
              | ((cfg_step == '0) & (cfg_start_inc != cfg_stop_inc));

   // At a leg end the current beat equals the limit, so the same
   // adder serves both the turn-around and the regular step.
   rb_clamp_addsub #(.W(INC_W)) u_clamp (
      .a   (m_axis_tdata),
      .b   (INC_W'(step_q)),
      .lo  (start_q),
      .hi  (stop_q),
      .sub (dir_n),
      .y   (sum)
   );

   assign nxt = reload ? start_q : sum;

   always_ff @(posedge clk_adc_125mhz or negedge adc_rstn_i) begin
      if (!adc_rstn_i) state <= RB_SWP_IDLE;
      else             state <= state_n;
   end

   always_comb begin
      state_n = state;
      dir_n = dir_dn;
      reload = 1'b0;
      term = 1'b0;
      if (!dir_dn && (m_axis_tdata == stop_q)) begin
         if (bidir_q && (start_q != stop_q)) dir_n = 1'b1;
         else if (rep_q)                     reload = 1'b1;
         else                                term = 1'b1;
      end else if (dir_dn && (m_axis_tdata == start_q)) begin
         if (rep_q) dir_n = 1'b0;
         else       term = 1'b1;
      end
      unique case (state)
         RB_SWP_IDLE: begin
            if (arm && !bad) state_n = RB_SWP_EMIT;
         end
         RB_SWP_EMIT: begin
            if (hs) begin
               if (term)                 state_n = RB_SWP_FIN;
               else if (dwell_q == '0)   state_n = RB_SWP_EMIT;
               else                      state_n = RB_SWP_DWELL;
            end
         end
         RB_SWP_DWELL: begin
            if (cnt == '0) state_n = RB_SWP_EMIT;
         end
         RB_SWP_FIN: state_n = RB_SWP_IDLE;
      endcase
      if (abort) state_n = RB_SWP_IDLE;
   end

   always_ff @(posedge clk_adc_125mhz or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         start_q      <= '0;
         stop_q       <= '0;
         step_q       <= '0;
         dwell_q      <= '0;
         rep_q        <= 1'b0;
         bidir_q      <= 1'b0;
         dir_dn       <= 1'b0;
         pend         <= '0;
         cnt          <= '0;
         m_axis_tdata <= '0;
         done         <= 1'b0;
         cfg_err      <= 1'b0;
         step_cnt     <= '0;
      end else begin
         done <= 1'b0;
         if (arm) begin
            start_q <= cfg_start_inc;
            stop_q  <= cfg_stop_inc;
            step_q  <= cfg_step;
            dwell_q <= cfg_dwell;
            rep_q   <= cfg_repeat;
            bidir_q <= cfg_bidir;
            if (bad) begin
               cfg_err <= 1'b1;
            end else begin
               cfg_err      <= 1'b0;
               step_cnt     <= '0;
               m_axis_tdata <= cfg_start_inc;
               dir_dn       <= 1'b0;
            end
         end else if (!abort) begin
            if (hs) begin
               if (step_cnt != '1) step_cnt <= step_cnt + 16'd1;
               dir_dn <= dir_n;
               if (term) begin
                  done <= 1'b1;
               end else if (dwell_q == '0) begin
                  m_axis_tdata <= nxt;
               end else begin
                  pend <= nxt;
                  cnt  <= dwell_q - DWELL_W'(1);
               end
            end else if (state == RB_SWP_DWELL) begin
               if (cnt == '0) m_axis_tdata <= pend;
               else           cnt <= cnt - DWELL_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_rb_osc1_sweep.sv
// Bench for rb_osc1_sweep: directed cases with literal beat lists plus
// randomized sweeps compared every cycle against a beat-list model.
module tb_rb_osc1_sweep;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] cfg_start_inc = '0;
   logic [47:0] cfg_stop_inc = '0;
   logic [31:0] cfg_step = '0;
   logic [15:0] cfg_dwell = '0;
   logic        cfg_repeat = 1'b0;
   logic        cfg_bidir = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        tvalid;
   logic        tready = 1'b0;
   logic [47:0] tdata;
   logic        busy;
   logic        done;
   logic        cfg_err;
   logic [15:0] step_cnt;

   always #5 clk = ~clk;

   rb_osc1_sweep dut (
      .clk_adc_125mhz (clk),
      .adc_rstn_i     (rst_n),
      .cfg_start_inc  (cfg_start_inc),
      .cfg_stop_inc   (cfg_stop_inc),
      .cfg_step       (cfg_step),
      .cfg_dwell      (cfg_dwell),
      .cfg_repeat     (cfg_repeat),
      .cfg_bidir      (cfg_bidir),
      .start          (start),
      .abort          (abort),
      .m_axis_tvalid  (tvalid),
      .m_axis_tready  (tready),
      .m_axis_tdata   (tdata),
      .busy           (busy),
      .done           (done),
      .cfg_err        (cfg_err),
      .step_cnt       (step_cnt)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // model: the full beat list of a sweep, walked one accepted beat at a time
   logic [63:0] seq[$];
   bit          m_term;
   bit          m_busy = 0, m_fin = 0, m_done = 0, m_err = 0;
   int          m_cnt = 0, m_idx = 0, m_gap = 0, m_dw = 0;
   logic [63:0] m_data = '0;

   logic [63:0] cap_v[$];
   int          cap_t[$];
   int          done_cnt = 0;
   int          done_t = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic build_seq(input logic [63:0] s, input logic [63:0] e,
                            input logic [63:0] st, input bit rp,
                            input bit bd);
      logic [63:0] u[$];
      logic [63:0] d[$];
      logic [63:0] v;
      v = s;
      for (int k = 0; k < 1100; k++) begin
         u.push_back(v);
         if (v == e) break;
         v = (v + st >= e) ? e : v + st;
      end
      if (bd && s != e) begin
         v = e;
         for (int k = 0; k < 1100; k++) begin
            v = (v < st || v - st <= s) ? s : v - st;
            d.push_back(v);
            if (v == s) break;
         end
      end
      seq = u;
      foreach (d[k]) seq.push_back(d[k]);
      m_term = !rp;
      while (rp && seq.size() < 1100) begin
         if (bd && s != e) begin
            for (int k = 1; k < u.size(); k++) seq.push_back(u[k]);
            foreach (d[k]) seq.push_back(d[k]);
         end else begin
            foreach (u[k]) seq.push_back(u[k]);
         end
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         m_busy = 0; m_fin = 0; m_done = 0; m_err = 0;
         m_cnt = 0; m_idx = 0; m_gap = 0; m_data = '0;
         return;
      end
      m_done = 0;
      if (abort) begin
         m_busy = 0;
         m_fin = 0;
      end else if (!m_busy) begin
         if (start) begin
            if (cfg_start_inc > cfg_stop_inc ||
                (cfg_step == 0 && cfg_start_inc != cfg_stop_inc)) begin
               m_err = 1;
            end else begin
               build_seq(64'(cfg_start_inc), 64'(cfg_stop_inc),
                         64'(cfg_step), cfg_repeat, cfg_bidir);
               m_dw = int'(cfg_dwell);
               m_err = 0; m_cnt = 0; m_idx = 0; m_gap = 0;
               m_data = seq[0];
               m_busy = 1;
            end
         end
      end else if (m_fin) begin
         m_busy = 0;
         m_fin = 0;
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) m_data = seq[m_idx];
      end else if (tready) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_term && m_idx == seq.size() - 1) begin
            m_fin = 1;
            m_done = 1;
         end else if (m_idx + 1 < seq.size()) begin
            m_idx++;
            m_gap = m_dw;
            if (m_gap == 0) m_data = seq[m_idx];
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) model_step();

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      chk("tvalid", tvalid, m_busy && !m_fin && m_gap == 0);
      chk("tdata", tdata, m_data);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("cfg_err", cfg_err, m_err);
      chk("step_cnt", step_cnt, 64'(m_cnt));
      if (rst_n) begin
         if (tvalid && tready) begin
            cap_v.push_back(64'(tdata));
            cap_t.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_t = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_cfg(input logic [47:0] s, input logic [47:0] e,
                          input logic [31:0] st, input logic [15:0] dw,
                          input bit rp, input bit bd);
      cfg_start_inc = s;
      cfg_stop_inc = e;
      cfg_step = st;
      cfg_dwell = dw;
      cfg_repeat = rp;
      cfg_bidir = bd;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max, input string nm);
      int k = 0;
      while (busy && k < max) begin
         tick();
         k++;
      end
      chk(nm, busy, 1'b0);
   endtask

   task automatic clr_cap();
      cap_v.delete();
      cap_t.delete();
   endtask

   initial begin
      logic [63:0] l1[4];
      logic [63:0] l3[7];
      logic [63:0] top;
      int k;
      int dc;
      l1 = '{100, 110, 120, 130};
      l3 = '{0, 10, 20, 10, 0, 10, 20};
      top = 64'h0000_FFFF_FFFF_FFFF;

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_cnt", step_cnt, 0);

      // single up sweep, back-to-back beats
      clr_cap();
      set_cfg(100, 130, 10, 0, 0, 0);
      tready = 1'b1;
      pulse_start();
      chk("t1_lat_valid", tvalid, 1);
      chk("t1_model_len", seq.size(), 4);
      for (int i = 0; i < 4; i++) chk("t1_model_seq", seq[i], l1[i]);
      wait_idle(20, "t1_idle");
      chk("t1_nbeats", cap_v.size(), 4);
      for (int i = 0; i < 4 && i < cap_v.size(); i++) begin
         chk("t1_beat", cap_v[i], l1[i]);
         if (i > 0) chk("t1_gap", cap_t[i] - cap_t[i-1], 1);
      end
      chk("t1_done_cnt", done_cnt, 1);
      if (cap_t.size() == 4) chk("t1_done_t", done_t - cap_t[3], 1);

      // clamp at stop with dwell
      clr_cap();
      set_cfg(0, 25, 10, 3, 0, 0);
      pulse_start();
      wait_idle(60, "t2_idle");
      chk("t2_nbeats", cap_v.size(), 4);
      for (int i = 0; i < 4 && i < cap_v.size(); i++) begin
         chk("t2_beat", cap_v[i], (i == 3) ? 64'd25 : 64'(i * 10));
         if (i > 0) chk("t2_gap", cap_t[i] - cap_t[i-1], 4);
      end
      chk("t2_cnt", step_cnt, 4);

      // bidirectional repeat, then abort
      clr_cap();
      dc = done_cnt;
      set_cfg(0, 20, 10, 0, 1, 1);
      pulse_start();
      for (int i = 0; i < 7; i++) chk("t3_model_seq", seq[i], l3[i]);
      k = 0;
      while (cap_v.size() < 7 && k < 40) begin
         tick();
         k++;
      end
      chk("t3_got7", cap_v.size() >= 7, 1);
      for (int i = 0; i < 7 && i < cap_v.size(); i++)
         chk("t3_beat", cap_v[i], l3[i]);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t3_abort_valid", tvalid, 0);
      chk("t3_abort_busy", busy, 0);
      tick();
      chk("t3_no_done", done_cnt, dc);

      // backpressure on beat 110
      clr_cap();
      set_cfg(100, 130, 10, 0, 0, 0);
      tready = 1'b0;
      pulse_start();
      tready = 1'b1;
      tick();
      tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_valid", tvalid, 1);
         chk("t4_hold_data", tdata, 110);
         chk("t4_hold_cnt", step_cnt, 1);
      end
      tready = 1'b1;
      wait_idle(20, "t4_idle");
      chk("t4_nbeats", cap_v.size(), 4);
      for (int i = 0; i < 4 && i < cap_v.size(); i++)
         chk("t4_beat", cap_v[i], l1[i]);
      chk("t4_cnt", step_cnt, 4);

      // bad config, then start+abort together
      set_cfg(50, 40, 10, 0, 0, 0);
      pulse_start();
      chk("t5_err", cfg_err, 1);
      chk("t5_busy", busy, 0);
      tick();
      chk("t5_valid", tvalid, 0);
      set_cfg(0, 20, 10, 0, 0, 0);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("t5_sa_busy", busy, 0);
      chk("t5_sa_err", cfg_err, 1);
      tick();
      chk("t5_sa_valid", tvalid, 0);

      // carry-out clamp near the top of the range
      clr_cap();
      dc = done_cnt;
      set_cfg(48'hFFFF_FFFF_FFE2, 48'hFFFF_FFFF_FFFF, 32'h8000_0000,
              0, 0, 0);
      pulse_start();
      wait_idle(20, "t6_idle");
      chk("t6_nbeats", cap_v.size(), 2);
      if (cap_v.size() == 2) begin
         chk("t6_beat0", cap_v[0], top - 29);
         chk("t6_beat1", cap_v[1], top);
      end
      chk("t6_done", done_cnt, dc + 1);

      // async reset in the middle of a sweep
      set_cfg(0, 1000, 1, 2, 1, 1);
      pulse_start();
      repeat (7) tick();
      chk("t6_mid_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_ar_valid", tvalid, 0);
      chk("t6_ar_data", tdata, 0);
      chk("t6_ar_busy", busy, 0);
      chk("t6_ar_cnt", step_cnt, 0);
      chk("t6_ar_done", done, 0);
      chk("t6_ar_err", cfg_err, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // randomized sweeps against the model
      for (int n = 0; n < 40; n++) begin
         logic [47:0] s;
         logic [47:0] e;
         logic [31:0] st;
         if ($urandom % 4 == 0)
            s = 48'hFFFF_FFFF_FF00 + 48'($urandom_range(0, 200));
         else
            s = 48'($urandom_range(0, 1000));
         e = s + 48'($urandom_range(0, 120));
         if (e < s) e = 48'hFFFF_FFFF_FFFF;
         if ($urandom % 8 == 0) e = s - 48'($urandom_range(1, 20));
         if ($urandom % 5 == 0) st = $urandom;
         else                   st = 32'($urandom_range(0, 40));
         set_cfg(s, e, st, 16'($urandom_range(0, 3)),
                 1'($urandom % 2), 1'($urandom % 2));
         tready = 1'($urandom % 2);
         pulse_start();
         for (int c = 0; c < 150; c++) begin
            tready = ($urandom % 10) < 7;
            start = ($urandom % 40) == 0;
            abort = ($urandom % 100) == 0;
            if ($urandom % 30 == 0)
               cfg_start_inc = 48'($urandom_range(0, 2000));
            tick();
            if (!busy) break;
         end
         start = 1'b0;
         abort = 1'b1;
         tick();
         abort = 1'b0;
         tready = 1'b1;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
